// File: rtl/klein_mixcolumn_seq.sv
// Sequential MixColumn/InvMixColumn engine: one 32-bit column per clock through a shared mix datapath.
// Define KLEIN_MIXCOL_INV_EN to honour iinv and build the inverse post-stage; otherwise forward only.
module klein_mixcolumn_seq #(
  parameter int NCOL = 2,
  parameter int CW   = 3
) (
  input  logic              iclk,
  input  logic              irst,
  input  logic              ivalid,
  output logic              oready,
  input  logic [32*NCOL-1:0] idata,
  input  logic              iinv,
  output logic              ovalid,
  input  logic              iready,
  output logic [32*NCOL-1:0] odata,
  output logic [1:0]        dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
  // Input: oready is 1 only in IDLE outside reset; ivalid must be held until then.
  // Output: ovalid stays 1 with odata stable until iready is seen.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state, state_nx;
  logic [CW-1:0]      cnt;
  logic [32*NCOL-1:0] work;
  logic               accept;
  logic               last_col;
  logic [31:0]        cur_col;
  logic [31:0]        mix_col;

  function automatic logic [7:0] gm2(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_fwd(input logic [31:0] c);
    logic [7:0] w0, w1, w2, w3;
    w0 = c[31:24];
    w1 = c[23:16];
    w2 = c[15:8];
    w3 = c[7:0];
    return {gm2(w0 ^ w1) ^ w1 ^ w2 ^ w3,
            gm2(w1 ^ w2) ^ w2 ^ w3 ^ w0,
            gm2(w2 ^ w3) ^ w3 ^ w0 ^ w1,
            gm2(w3 ^ w0) ^ w0 ^ w1 ^ w2};
  endfunction

`ifdef KLEIN_MIXCOL_INV_EN
  logic mode;

  // InvMixColumn factors as MixColumn followed by this cheap circulant correction.
  function automatic logic [31:0] inv_post(input logic [31:0] a);
    logic [7:0] u, v;
    u = gm2(gm2(a[31:24] ^ a[15:8]));
    v = gm2(gm2(a[23:16] ^ a[7:0]));
    return {u ^ a[31:24], v ^ a[23:16], u ^ a[15:8], v ^ a[7:0]};
  endfunction

  always_comb begin
    mix_col = mix_fwd(cur_col);
    if (mode) mix_col = inv_post(mix_fwd(cur_col));
  end
`else
  logic unused_iinv;
  assign unused_iinv = iinv;

  always_comb begin
    mix_col = mix_fwd(cur_col);
  end
`endif

  assign accept   = (state == IDLE) && ivalid && !irst;
  assign last_col = (cnt == CW'(NCOL - 1));

  always_comb begin
    cur_col = '0;
    for (int i = 0; i < NCOL; i++) begin
      if (cnt == CW'(i)) cur_col = work[32*(NCOL-1-i) +: 32];
    end
  end

  always_ff @(posedge iclk) begin
    if (irst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    oready   = 1'b0;
    ovalid   = 1'b0;
    case (state)
      IDLE: begin
        oready = !irst;
        if (ivalid) state_nx = BUSY;
      end
      BUSY: begin
        if (last_col) state_nx = DONE;
      end
      DONE: begin
        ovalid = 1'b1;
        if (iready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge iclk) begin
    if (irst) begin
      work <= '0;
      cnt  <= '0;
`ifdef KLEIN_MIXCOL_INV_EN
      mode <= 1'b0;
`endif
    end else if (accept) begin
      work <= idata;
      cnt  <= '0;
`ifdef KLEIN_MIXCOL_INV_EN
      mode <= iinv;
`endif
    end else if (state == BUSY) begin
      for (int i = 0; i < NCOL; i++) begin
        if (cnt == CW'(i)) work[32*(NCOL-1-i) +: 32] <= mix_col;
      end
      cnt <= cnt + CW'(1);
    end
  end

  assign odata     = work;
  assign dbg_state = state;

endmodule

// File: tb/tb_klein_mixcolumn_seq.sv
// Bench for klein_mixcolumn_seq: NCOL=2 and NCOL=4 instances checked against a GF(2^8) matrix model.
module tb_klein_mixcolumn_seq;

  logic         clk;
  logic         rst;

  logic         ivalid2, oready2, iinv2, ovalid2, iready2;
  logic [63:0]  idata2, odata2;
  logic [1:0]   dbg2;

  logic         ivalid4, oready4, iinv4, ovalid4, iready4;
  logic [127:0] idata4, odata4;
  logic [1:0]   dbg4;

  int checks;
  int errors;
  logic [63:0] exp_q[$];

  klein_mixcolumn_seq #(.NCOL(2), .CW(3)) dut2 (
    .iclk(clk), .irst(rst), .ivalid(ivalid2), .oready(oready2), .idata(idata2),
    .iinv(iinv2), .ovalid(ovalid2), .iready(iready2), .odata(odata2), .dbg_state(dbg2)
  );

  klein_mixcolumn_seq #(.NCOL(4), .CW(3)) dut4 (
    .iclk(clk), .irst(rst), .ivalid(ivalid4), .oready(oready4), .idata(idata4),
    .iinv(iinv4), .ovalid(ovalid4), .iready(iready4), .odata(odata4), .dbg_state(dbg4)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // reference model: circulant matrix product over GF(2^8)
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p  = 8'h00;
    aa = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
    end
    return p;
  endfunction

  function automatic logic [31:0] model_col(input logic [31:0] c, input logic inv);
    logic [7:0] m[4];
    logic [7:0] w[4];
    logic [7:0] b;
    logic [31:0] r;
    if (inv) m = '{8'd14, 8'd11, 8'd13, 8'd9};
    else     m = '{8'd2, 8'd3, 8'd1, 8'd1};
    for (int i = 0; i < 4; i++) w[i] = c[31-8*i -: 8];
    r = '0;
    for (int i = 0; i < 4; i++) begin
      b = 8'h00;
      for (int j = 0; j < 4; j++) b = b ^ gmul(m[(j - i + 4) % 4], w[j]);
      r[31-8*i -: 8] = b;
    end
    return r;
  endfunction

  function automatic logic [127:0] model_state(input logic [127:0] d, input int ncol, input logic inv);
    logic [127:0] r;
    logic ei;
`ifdef KLEIN_MIXCOL_INV_EN
    ei = inv;
`else
    ei = 1'b0;
`endif
    r = '0;
    for (int c = 0; c < ncol; c++)
      r[32*(ncol-1-c) +: 32] = model_col(d[32*(ncol-1-c) +: 32], ei);
    return r;
  endfunction

  // driver tasks: wait for ready, transfer one state, return result and latency
  task automatic run2(input logic [63:0] d, input logic inv, input int stall,
                      output logic [63:0] res, output int lat);
    int n;
    n = 0;
    while (!oready2 && n < 100) begin @(negedge clk); n++; end
    ivalid2 = 1'b1; idata2 = d; iinv2 = inv; iready2 = (stall == 0);
    @(negedge clk);
    ivalid2 = 1'b0; idata2 = {$urandom, $urandom}; iinv2 = 1'($urandom);
    lat = 1;
    while (!ovalid2 && lat < 100) begin @(negedge clk); lat++; end
    if (!ovalid2) lat = -1;
    res = odata2;
    repeat (stall) @(negedge clk);
    iready2 = 1'b1;
    @(negedge clk);
  endtask

  task automatic run4(input logic [127:0] d, input logic inv,
                      output logic [127:0] res, output int lat);
    int n;
    n = 0;
    while (!oready4 && n < 100) begin @(negedge clk); n++; end
    ivalid4 = 1'b1; idata4 = d; iinv4 = inv; iready4 = 1'b1;
    @(negedge clk);
    ivalid4 = 1'b0; idata4 = {$urandom, $urandom, $urandom, $urandom}; iinv4 = 1'($urandom);
    lat = 1;
    while (!ovalid4 && lat < 100) begin @(negedge clk); lat++; end
    if (!ovalid4) lat = -1;
    res = odata4;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (oready2 !== 1'b0) begin errors++; $display("FAIL reset_oready2: got %b expected 0", oready2); end
    checks++; if (ovalid2 !== 1'b0) begin errors++; $display("FAIL reset_ovalid2: got %b expected 0", ovalid2); end
    checks++; if (odata2 !== 64'h0) begin errors++; $display("FAIL reset_odata2: got %h expected 0", odata2); end
    checks++; if (odata4 !== 128'h0) begin errors++; $display("FAIL reset_odata4: got %h expected 0", odata4); end
    rst = 1'b0;
    #1;
    checks++; if (oready2 !== 1'b1) begin errors++; $display("FAIL idle_oready2: got %b expected 1", oready2); end
    checks++; if (oready4 !== 1'b1) begin errors++; $display("FAIL idle_oready4: got %b expected 1", oready4); end
    @(negedge clk);
  endtask

  task automatic test_vectors;
    logic [63:0]  r2, e2;
    logic [127:0] r4;
    int lat;
    run2(64'hdb135345_f20a225c, 1'b0, 0, r2, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL fwd2_latency: got %0d expected 3", lat); end
    checks++; if (r2 !== 64'h8e4da1bc_9fdc589d) begin errors++; $display("FAIL fwd2_data: got %h expected 8e4da1bc9fdc589d", r2); end
    checks++; if (oready2 !== 1'b1 || ovalid2 !== 1'b0) begin errors++; $display("FAIL fwd2_release: got oready=%b ovalid=%b expected 1/0", oready2, ovalid2); end
    run2(64'h8e4da1bc_9fdc589d, 1'b1, 0, r2, lat);
`ifdef KLEIN_MIXCOL_INV_EN
    e2 = 64'hdb135345_f20a225c;
`else
    e2 = 64'(model_state({64'h0, 64'h8e4da1bc_9fdc589d}, 2, 1'b0));
`endif
    checks++; if (r2 !== e2) begin errors++; $display("FAIL inv2_data: got %h expected %h", r2, e2); end
    run4(128'h01010101_c6c6c6c6_d4d4d4d5_2d26314c, 1'b0, r4, lat);
    checks++; if (lat !== 5) begin errors++; $display("FAIL fwd4_latency: got %0d expected 5", lat); end
    checks++; if (r4 !== 128'h01010101_c6c6c6c6_d5d5d7d6_4d7ebdf8) begin errors++; $display("FAIL fwd4_data: got %h expected 01010101c6c6c6c6d5d5d7d64d7ebdf8", r4); end
  endtask

  task automatic test_backpressure;
    logic [63:0] d, e;
    int n;
    d = {$urandom, $urandom};
    e = 64'(model_state({64'h0, d}, 2, 1'b1));
    ivalid2 = 1'b1; idata2 = d; iinv2 = 1'b1; iready2 = 1'b0;
    @(negedge clk);
    ivalid2 = 1'b0;
    n = 0;
    while (!ovalid2 && n < 50) begin @(negedge clk); n++; end
    checks++; if (ovalid2 !== 1'b1) begin errors++; $display("FAIL bp_ovalid_timeout: got %b expected 1", ovalid2); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      ivalid2 = 1'($urandom); iinv2 = 1'($urandom); idata2 = {$urandom, $urandom};
      #1;
      checks++; if (ovalid2 !== 1'b1) begin errors++; $display("FAIL bp_ovalid_hold: got %b expected 1", ovalid2); end
      checks++; if (odata2 !== e) begin errors++; $display("FAIL bp_odata_hold: got %h expected %h", odata2, e); end
      checks++; if (oready2 !== 1'b0) begin errors++; $display("FAIL bp_oready: got %b expected 0", oready2); end
    end
    @(negedge clk);
    ivalid2 = 1'b0; iready2 = 1'b1;
    @(negedge clk);
    checks++; if (ovalid2 !== 1'b0 || oready2 !== 1'b1) begin errors++; $display("FAIL bp_release: got ovalid=%b oready=%b expected 0/1", ovalid2, oready2); end
  endtask

  task automatic test_reset_mid;
    logic [127:0] d, r4, e4;
    int lat;
    ivalid4 = 1'b1; idata4 = {$urandom, $urandom, $urandom, $urandom}; iinv4 = 1'b0; iready4 = 1'b1;
    @(negedge clk);
    ivalid4 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (oready4 !== 1'b0) begin errors++; $display("FAIL rstmid_oready_in_reset: got %b expected 0", oready4); end
    @(negedge clk);
    checks++; if (ovalid4 !== 1'b0) begin errors++; $display("FAIL rstmid_ovalid: got %b expected 0", ovalid4); end
    checks++; if (odata4 !== 128'h0) begin errors++; $display("FAIL rstmid_odata: got %h expected 0", odata4); end
    rst = 1'b0;
    #1;
    checks++; if (oready4 !== 1'b1) begin errors++; $display("FAIL rstmid_idle: got %b expected 1", oready4); end
    d  = {$urandom, $urandom, $urandom, $urandom};
    e4 = model_state(d, 4, 1'b1);
    run4(d, 1'b1, r4, lat);
    checks++; if (lat !== 5) begin errors++; $display("FAIL rstmid_after_latency: got %0d expected 5", lat); end
    checks++; if (r4 !== e4) begin errors++; $display("FAIL rstmid_after_data: got %h expected %h", r4, e4); end
  endtask

  task automatic test_back_to_back;
    logic [63:0] a, b;
    int acc_t[$];
    logic [63:0] got[$];
    logic [63:0] e;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    exp_q.push_back(64'(model_state({64'h0, a}, 2, 1'b0)));
    exp_q.push_back(64'(model_state({64'h0, b}, 2, 1'b0)));
    iready2 = 1'b1; ivalid2 = 1'b1; idata2 = a; iinv2 = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (c > 0) @(negedge clk);
      if (ovalid2) got.push_back(odata2);
      if (acc_t.size() == 1) idata2 = b;
      if (acc_t.size() >= 2) ivalid2 = 1'b0;
      if (ivalid2 && oready2) acc_t.push_back(c);
    end
    ivalid2 = 1'b0;
    checks++; if (acc_t.size() !== 2) begin errors++; $display("FAIL b2b_accepts: got %0d expected 2", acc_t.size()); end
    else begin
      checks++; if (acc_t[1] - acc_t[0] !== 4) begin errors++; $display("FAIL b2b_spacing: got %0d expected 4", acc_t[1] - acc_t[0]); end
    end
    checks++; if (got.size() !== 2) begin errors++; $display("FAIL b2b_results: got %0d expected 2", got.size()); end
    while (exp_q.size() > 0 && got.size() > 0) begin
      e = exp_q.pop_front();
      checks++; if (got[0] !== e) begin errors++; $display("FAIL b2b_data: got %h expected %h", got[0], e); end
      void'(got.pop_front());
    end
    exp_q.delete();
  endtask

  task automatic test_random;
    logic [63:0]  d2, r2, e2;
    logic [127:0] d4, r4, e4;
    logic inv;
    int lat;
    for (int i = 0; i < 12; i++) begin
      d2  = {$urandom, $urandom};
      inv = 1'($urandom);
      exp_q.push_back(64'(model_state({64'h0, d2}, 2, inv)));
      run2(d2, inv, $urandom_range(0, 3), r2, lat);
      e2 = exp_q.pop_front();
      checks++; if (lat !== 3) begin errors++; $display("FAIL rand2_latency: got %0d expected 3", lat); end
      checks++; if (r2 !== e2) begin errors++; $display("FAIL rand2_data: got %h expected %h", r2, e2); end
    end
    for (int i = 0; i < 6; i++) begin
      d4  = {$urandom, $urandom, $urandom, $urandom};
      inv = 1'($urandom);
      e4  = model_state(d4, 4, inv);
      run4(d4, inv, r4, lat);
      checks++; if (r4 !== e4) begin errors++; $display("FAIL rand4_data: got %h expected %h", r4, e4); end
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1;
    ivalid2 = 1'b0; idata2 = '0; iinv2 = 1'b0; iready2 = 1'b1;
    ivalid4 = 1'b0; idata4 = '0; iinv4 = 1'b0; iready4 = 1'b1;
    @(negedge clk);
    test_reset();
    test_vectors();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
